// File: rtl/neo_pkg.sv
// ---------------------------------------------------------------------------
// neo_pkg
//   Shared types and colour table for the NeoPixel pattern sequencer.
//   color_t     : colour slot within a pixel (RED, GREEN, BLUE).
//   seq_state_t : sequencer FSM states (LOAD, SEND, WAIT).
//   palette_level(step, colour) : 8-bit intensity of one colour for a
//                 chaser step, taken from the 8-entry RGB palette.
// ---------------------------------------------------------------------------
package neo_pkg;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2
  } color_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } seq_state_t;

  // Palette stored as packed 24-bit RGB words, one per chaser step.
  function automatic logic [7:0] palette_level(input logic [2:0] step,
                                               input color_t     colour);
    logic [23:0] rgb;
    logic [7:0]  lvl;
    case (step)
      3'd0:    rgb = 24'hFF_00_00;
      3'd1:    rgb = 24'h00_FF_00;
      3'd2:    rgb = 24'h00_00_FF;
      3'd3:    rgb = 24'hFF_FF_00;
      3'd4:    rgb = 24'h00_FF_FF;
      3'd5:    rgb = 24'hFF_00_FF;
      3'd6:    rgb = 24'h40_40_40;
      default: rgb = 24'hFF_40_00;
    endcase
    case (colour)
      RED:     lvl = rgb[23:16];
      GREEN:   lvl = rgb[15:8];
      default: lvl = rgb[7:0];
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/neo_frame_timer.sv
// ---------------------------------------------------------------------------
// neo_frame_timer
//   Gated up-counter that measures the inter-frame interval.
//   Ports:
//     clock  in  system clock
//     reset  in  asynchronous active-low reset (count -> 0)
//     clear  in  synchronous clear of the count
//     run    in  count advances on cycles where run==1
//     done   out high combinationally when count==FRAME_CYCLES-1 && run
// ---------------------------------------------------------------------------
module neo_frame_timer #(
  parameter int FRAME_CYCLES = 1_500_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic done
);

  // One spare code above FRAME_CYCLES-1 so the terminal increment never wraps.
  localparam int TW = $clog2(FRAME_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(FRAME_CYCLES - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = count_q + TW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = run && (count_q == LAST);

endmodule

// File: rtl/neo_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// neo_pattern_sequencer
//   Pattern source for the NeoPixel strand controller. Each frame it loads
//   every colour of every pixel, requests one transmission, waits a frame
//   interval and advances a colour-chaser step.
//   Ports:
//     clock          in   system clock
//     reset          in   asynchronous active-low reset
//     run            in   1 = frame timer advances in WAIT
//     ready_to_load  in   controller accepts load_color this cycle
//     ready_to_send  in   controller accepts send_it this cycle
//     load_color     out  load strobe (pixel_index/color_index/color_level valid)
//     pixel_index    out  pixel being loaded
//     color_index    out  0=red 1=green 2=blue
//     color_level    out  intensity for (pixel_index, color_index)
//     send_it        out  one-cycle transmit request
//     step           out  current chaser step
//   Build option: define NEO_SEQ_TAIL_EN to light the pixel behind the active
//   one at quarter intensity.
// ---------------------------------------------------------------------------
module neo_pattern_sequencer
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS   = 5,
  parameter int NUM_STEPS    = 8,
  parameter int FRAME_CYCLES = 1_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       ready_to_load,
  input  logic       ready_to_send,
  output logic       load_color,
  output logic [2:0] pixel_index,
  output logic [1:0] color_index,
  output logic [7:0] color_level,
  output logic       send_it,
  output logic [2:0] step
);

  localparam logic [2:0] LAST_PIX  = 3'(NUM_PIXELS - 1);
  localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

  seq_state_t state_q, state_d;
  logic [2:0] pix_q, pix_d;
  color_t     col_q, col_d;
  logic [2:0] step_q, step_d;

  logic       timer_clear;
  logic       timer_done;
  logic [2:0] active_pix;
  logic [7:0] pal_lvl;
  logic [7:0] pix_lvl;

  // Timer only counts while waiting; it is cleared on the accepted send.
  neo_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clear),
    .run   (run && (state_q == WAIT)),
    .done  (timer_done)
  );

  assign active_pix = 3'(32'(step_q) % NUM_PIXELS);
  assign pal_lvl    = palette_level(step_q, col_q);

`ifdef NEO_SEQ_TAIL_EN
  logic [2:0] tail_pix;
  assign tail_pix = (active_pix == 3'd0) ? LAST_PIX : (active_pix - 3'd1);

  // Active pixel is tested first so that with a single pixel it wins.
  always_comb begin
    pix_lvl = 8'd0;
    if (pix_q == active_pix) begin
      pix_lvl = pal_lvl;
    end else if (pix_q == tail_pix) begin
      pix_lvl = pal_lvl >> 2;
    end
  end
`else
  assign pix_lvl = (pix_q == active_pix) ? pal_lvl : 8'd0;
`endif

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    col_d       = col_q;
    step_d      = step_q;
    timer_clear = 1'b0;
    load_color  = 1'b0;
    send_it     = 1'b0;
    pixel_index = 3'd0;
    color_index = 2'd0;
    color_level = 8'd0;

    case (state_q)
      LOAD: begin
        // Gated by reset so nothing leaks out while reset is held.
        if (reset) begin
          load_color  = ready_to_load;
          pixel_index = pix_q;
          color_index = col_q;
          color_level = pix_lvl;
          if (ready_to_load) begin
            if (col_q == BLUE) begin
              col_d = RED;
              if (pix_q == LAST_PIX) begin
                pix_d   = 3'd0;
                state_d = SEND;
              end else begin
                pix_d = pix_q + 3'd1;
              end
            end else begin
              col_d = color_t'(col_q + 2'd1);
            end
          end
        end
      end
      SEND: begin
        send_it = ready_to_send;
        if (ready_to_send) begin
          timer_clear = 1'b1;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (timer_done) begin
          step_d  = (step_q == LAST_STEP) ? 3'd0 : (step_q + 3'd1);
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      pix_q   <= 3'd0;
      col_q   <= RED;
      step_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      col_q   <= col_d;
      step_q  <= step_d;
    end
  end

  assign step = reset ? step_q : 3'd0;

endmodule

// File: tb/tb_neo_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neo_pattern_sequencer
//   Self-checking bench for neo_pattern_sequencer with FRAME_CYCLES=10,
//   NUM_PIXELS=5, NUM_STEPS=8. Expected load data is derived from the
//   frame-level rules (k-th load of a frame = pixel k/3, colour k%3).
// ---------------------------------------------------------------------------
module tb_neo_pattern_sequencer;

  localparam int FC = 10;
  localparam int NP = 5;
  localparam int NS = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       run;
  logic       ready_to_load;
  logic       ready_to_send;
  logic       load_color;
  logic [2:0] pixel_index;
  logic [1:0] color_index;
  logic [7:0] color_level;
  logic       send_it;
  logic [2:0] step;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_send_cyc = 0;
  int model_step = 0;

  neo_pattern_sequencer #(
    .NUM_PIXELS  (NP),
    .NUM_STEPS   (NS),
    .FRAME_CYCLES(FC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .run          (run),
    .ready_to_load(ready_to_load),
    .ready_to_send(ready_to_send),
    .load_color   (load_color),
    .pixel_index  (pixel_index),
    .color_index  (color_index),
    .color_level  (color_level),
    .send_it      (send_it),
    .step         (step)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] ref_level(input int st, input int px, input int c);
    logic [23:0] rgb;
    logic [7:0]  v;
    int          act;
    case (st)
      0: rgb = 24'hFF0000;
      1: rgb = 24'h00FF00;
      2: rgb = 24'h0000FF;
      3: rgb = 24'hFFFF00;
      4: rgb = 24'h00FFFF;
      5: rgb = 24'hFF00FF;
      6: rgb = 24'h404040;
      default: rgb = 24'hFF4000;
    endcase
    v = (c == 0) ? rgb[23:16] : (c == 1) ? rgb[15:8] : rgb[7:0];
    act = st % NP;
    if (px == act) return v;
`ifdef NEO_SEQ_TAIL_EN
    if (px == (act + NP - 1) % NP) return v >> 2;
`endif
    return 8'h00;
  endfunction

  // One frame: 15 loads then one send. rdy_mode 0=always, 1=1,0,0,1 pattern,
  // 2=random. When reset_at>0, reset is asserted on that load and the task
  // returns early.
  task automatic run_frame(input int rdy_mode, input bit first_must_load,
                           input int exp_gap, input int reset_at);
    bit   pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   k = 0;
    int   n = 0;
    bit   sent = 1'b0;
    logic [2:0] ep;
    logic [1:0] ec;
    logic [7:0] el;
    while (k < NP * 3 && n < 200) begin
      @(negedge clock);
      case (rdy_mode)
        0:       ready_to_load = 1'b1;
        1:       ready_to_load = pat[n % 4];
        default: ready_to_load = 1'($urandom_range(0, 1));
      endcase
      if (first_must_load && n == 0) ready_to_load = 1'b1;
      ready_to_send = 1'($urandom_range(0, 1));
      run = 1'($urandom_range(0, 1));
      #1;
      n++;
      ep = 3'(k / 3);
      ec = 2'(k % 3);
      el = ref_level(model_step, k / 3, k % 3);
      checks++;
      if (load_color !== ready_to_load) begin
        errors++;
        $display("FAIL load_strobe k=%0d got %b want %b", k, load_color, ready_to_load);
      end
      checks++;
      if ({pixel_index, color_index, color_level} !== {ep, ec, el}) begin
        errors++;
        $display("FAIL load_data step=%0d k=%0d got p%0d c%0d %h want p%0d c%0d %h",
                 model_step, k, pixel_index, color_index, color_level, ep, ec, el);
      end
      checks++;
      if (send_it !== 1'b0 || step !== 3'(model_step)) begin
        errors++;
        $display("FAIL load_ctrl send_it=%b step=%0d want send_it=0 step=%0d",
                 send_it, step, model_step);
      end
      if (first_must_load && n == 1 && exp_gap > 0) begin
        checks++;
        if (cyc - last_send_cyc != exp_gap) begin
          errors++;
          $display("FAIL frame_gap got %0d want %0d", cyc - last_send_cyc, exp_gap);
        end
      end
      if (load_color === 1'b1) begin
        k++;
        if (k == reset_at) begin
          reset = 1'b0;
          #1;
          checks++;
          if ({load_color, send_it, pixel_index, color_index, color_level, step} !== 16'd0) begin
            errors++;
            $display("FAIL reset_midframe got ld=%b snd=%b p=%0d c=%0d l=%h s=%0d want all 0",
                     load_color, send_it, pixel_index, color_index, color_level, step);
          end
          return;
        end
      end
    end
    if (k < NP * 3) begin
      errors++;
      $display("FAIL load_timeout loads=%0d want %0d", k, NP * 3);
    end
    n = 0;
    while (!sent && n < 200) begin
      @(negedge clock);
      ready_to_load = 1'b1;
      ready_to_send = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      n++;
      checks++;
      if ({load_color, pixel_index, color_index, color_level} !== 14'd0 ||
          send_it !== ready_to_send || step !== 3'(model_step)) begin
        errors++;
        $display("FAIL send_phase got ld=%b snd=%b p=%0d c=%0d l=%h s=%0d want ld=0 snd=%b zeros s=%0d",
                 load_color, send_it, pixel_index, color_index, color_level, step,
                 ready_to_send, model_step);
      end
      if (send_it === 1'b1) begin
        sent = 1'b1;
        last_send_cyc = cyc;
      end
    end
    if (!sent) begin
      errors++;
      $display("FAIL send_timeout send_it never seen want 1");
    end
  endtask

  // Frame interval. run_mode 0=always 1, 1=low for the first 4 cycles, 2=random.
  task automatic run_wait(input int run_mode);
    int runs = 0;
    int n = 0;
    while (runs < FC && n < 500) begin
      @(negedge clock);
      ready_to_load = 1'b1;
      ready_to_send = 1'b1;
      case (run_mode)
        0:       run = 1'b1;
        1:       run = (n < 4) ? 1'b0 : 1'b1;
        default: run = 1'($urandom_range(0, 1));
      endcase
      #1;
      n++;
      checks++;
      if ({load_color, send_it, pixel_index, color_index, color_level} !== 15'd0 ||
          step !== 3'(model_step)) begin
        errors++;
        $display("FAIL wait_phase got ld=%b snd=%b p=%0d c=%0d l=%h s=%0d want zeros s=%0d",
                 load_color, send_it, pixel_index, color_index, color_level, step, model_step);
      end
      if (run) runs++;
    end
    if (runs < FC) begin
      errors++;
      $display("FAIL wait_timeout runs=%0d want %0d", runs, FC);
    end
    model_step = (model_step + 1) % NS;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run = 1'b1;
    ready_to_load = 1'b1;
    ready_to_send = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({load_color, send_it, pixel_index, color_index, color_level, step} !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got ld=%b snd=%b p=%0d c=%0d l=%h s=%0d want all 0",
               load_color, send_it, pixel_index, color_index, color_level, step);
    end
    @(negedge clock);
    ready_to_load = 1'b0;
    reset = 1'b1;
    model_step = 0;
  endtask

  task automatic test_first_frame();
    run_frame(0, 1'b0, -1, 0);
    run_wait(0);
  endtask

  task automatic test_ready_toggle_and_run_gate();
    run_frame(1, 1'b1, FC + 1, 0);
    run_wait(1);
    run_frame(0, 1'b1, FC + 1 + 4, 0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 8; f++) begin
      run_wait(2);
      run_frame(2, 1'b1, -1, 0);
    end
  endtask

  task automatic test_mid_frame_reset();
    run_wait(0);
    run_frame(0, 1'b1, FC + 1, 7);
    @(negedge clock);
    ready_to_load = 1'b0;
    reset = 1'b1;
    model_step = 0;
    run_frame(0, 1'b0, -1, 0);
    run_wait(0);
    run_frame(2, 1'b1, FC + 1, 0);
  endtask

  initial begin
    reset = 1'b0;
    run = 1'b0;
    ready_to_load = 1'b0;
    ready_to_send = 1'b0;
    test_reset();
    test_first_frame();
    test_ready_toggle_and_run_gate();
    test_back_to_back();
    test_mid_frame_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
